mdio_master: RTL
================

// Module: mdio_master
// PURPOSE
// - Clause 22 MDIO management-frame engine. Sits directly downstream of the AXI4-Lite
//   register front end and takes one read/write command at a time.
// - Serialises preamble, ST, OP, PHYAD, REGAD, TA and DATA onto MDC/MDIO.
// - Returns read data or write completion on a valid/ready response channel.
// - The top level resolves the pad: mdio = mdio_oe ? mdio_o : 1'bz; mdio_i = mdio.
// PARAMETERS
// - CLK_DIV  2   aclk cycles per MDC half-period; legal >=2; MDC period = 2*CLK_DIV.
// - PRE_LEN  32  preamble bits of '1' sent before ST; legal 0 (suppressed) .. 32.
// PORTS
// - aclk        in   1   single clock, all logic rising-edge.
// - areset      in   1   asynchronous, active-high reset.
// - cmd_valid   in   1   command offered.
// - cmd_ready   out  1   engine can accept a command.
// - cmd_write   in   1   1 = write (OP=01), 0 = read (OP=10).
// - cmd_phyad   in   5   PHY address.
// - cmd_regad   in   5   register address.
// - cmd_wdata   in   16  write data; ignored for reads.
// - rsp_valid   out  1   response held until accepted.
// - rsp_ready   in   1   response consumer ready.
// - rsp_rdata   out  16  read data; 0 for writes.
// - rsp_err     out  1   read only: PHY did not drive TA bit 2 low.
// - busy        out  1   frame in progress or response pending.
// - mdc         out  1   management clock; low when idle.
// - mdio_o      out  1   MDIO drive value.
// - mdio_oe     out  1   MDIO output enable.
// - mdio_i      in   1   MDIO pad input; external pull-up assumed.
// BEHAVIOUR
// - Reset (async, immediate, also mid-frame):
//   - mdc=0, mdio_o=1, mdio_oe=0, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//     busy=0, FSM=IDLE.
//   - No partial response is generated.
// - cmd_ready = (state==IDLE) && !rsp_valid.
//   - Accept on cmd_valid&&cmd_ready in cycle T; latch all cmd_* fields.
//   - Command inputs are ignored thereafter.
// - Bit timing: each bit is 2*CLK_DIV aclk cycles.
//   - The bit starts at the aclk edge where mdc falls (first bit starts at T+1 with mdc=0).
//   - mdc rises after CLK_DIV cycles.
//   - mdio_o/mdio_oe update only at bit start.
//   - mdio_i is registered at the edge where mdc rises.
// - FSM: IDLE -> PRE(PRE_LEN bits of 1) -> HDR(14 bits: ST=01,OP,PHYAD,REGAD, MSB first)
//   -> TA(2) -> DATA(16, MSB first) -> DONE -> IDLE.
//   - PRE_LEN=0 skips PRE.
//   - A 5-bit down-counter plus 16-bit shift register track bits.
// - Write: mdio_oe=1 through PRE/HDR/TA/DATA; TA driven 1,0; DATA = cmd_wdata.
// - Read: mdio_oe=1 through PRE/HDR.
//   - mdio_oe=0 from TA bit 1 through DATA.
//   - TA bit 2 sample ==1 -> rsp_err=1.
//   - The 16 DATA samples shift into rsp_rdata; they are captured even on error
//     (typically 0xFFFF).
// - DONE: at the falling-edge point ending the last DATA bit:
//   - mdc=0, mdio_oe=0, rsp_valid=1.
//   - rsp_valid is asserted at cycle T+1+(PRE_LEN+32)*2*CLK_DIV.
// - Response: rsp_valid/rsp_rdata/rsp_err stay stable until rsp_valid&&rsp_ready.
//   - rsp_valid clears the next cycle; cmd_ready rises the same cycle.
//   - No command accepted while a response is pending.
// - Back-to-back: minimum one idle aclk cycle (mdc low) between frames.
// - Widths: counters sized for max(PRE_LEN,16); no arithmetic on data fields.
// STRUCTURE
// - mdio_pkg.vh: MDIO_ST=2'b01, MDIO_OP_WR=2'b01, MDIO_OP_RD=2'b10, FSM state encodings
//   (IDLE,PRE,HDR,TA,DATA,DONE), frame field widths.
// - Sub-module mdio_clkgen: CLK_DIV counter producing mdc plus one-cycle fall_stb/rise_stb.
//   - Enabled only while a frame is active; resets mdc low.
// TESTING
// - Write (CLK_DIV=2, PRE_LEN=32) phyad=1 regad=0 wdata=0x1140:
//   - mdio at rising mdc = 32x'1', then 01 01 00001 00000 10 0001000101000000.
//   - rsp_valid at T+257, rsp_err=0.
// - Read phyad=3 regad=2, PHY model drives TA2=0 and 0x796D after mdc rise:
//   - mdio_oe=0 from TA1; rsp_rdata=0x796D, rsp_err=0.
// - Read with no PHY (mdio_i held 1): rsp_err=1, rsp_rdata=0xFFFF.
// - Command offered while busy and with rsp_ready=0 for 10 cycles:
//   - cmd_ready=0 throughout; response stable.
//   - Next command accepted the cycle after the handshake.
// - areset pulsed during HDR bit 5:
//   - mdc=0, mdio_oe=0, rsp_valid=0 immediately.
//   - A fresh write after reset produces a correct full frame.
// - PRE_LEN=0, CLK_DIV=3 write: no preamble, frame starts with 01; rsp_valid at T+193.

Source files
------------

// File: rtl/mdio_master_pkg.sv
// mdio_master_pkg: shared frame constants and FSM encoding for the Clause 22 MDIO engine
package mdio_master_pkg;
  localparam logic [1:0] MDIO_ST = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int HDR_BITS = 14;
  localparam int CNT_W = 5;
  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;
endpackage

// File: rtl/mdio_master_if.sv
// mdio_master_if: command and response channels between the register front end and the MDIO engine
interface mdio_master_if;
  import mdio_master_pkg::*;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_phyad, cmd_regad;
  logic [DATA_W-1:0] cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  modport master(output cmd_valid, cmd_write, cmd_phyad, cmd_regad, cmd_wdata, rsp_ready,
                 input cmd_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input cmd_valid, cmd_write, cmd_phyad, cmd_regad, cmd_wdata, rsp_ready,
                output cmd_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/mdio_master_clkgen.sv
// mdio_master_clkgen: divides aclk into mdc, with one-cycle strobes preceding each mdc edge
module mdio_master_clkgen #(parameter int CLK_DIV = 2) (
  input  logic aclk,
  input  logic areset,
  input  logic en,
  output logic mdc,
  output logic fall_stb,
  output logic rise_stb
);
  localparam int CW = $clog2(2 * CLK_DIV);
  logic [CW-1:0] cnt;
  assign fall_stb = en && cnt == '0;
  assign rise_stb = en && cnt == CW'(CLK_DIV);
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else begin
      cnt <= (en && cnt != CW'(2 * CLK_DIV - 1)) ? cnt + 1'b1 : '0;
      mdc <= en && (rise_stb || (mdc && !fall_stb));
    end
endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause 22 MDIO frame engine serialising one read/write command onto mdc/mdio
module mdio_master
  import mdio_master_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int PRE_LEN = 32
) (
  input  logic         aclk,
  input  logic         areset,
  mdio_master_if.slave bus,
  output logic         busy,
  output logic         mdc,
  output logic         mdio_o,
  output logic         mdio_oe,
  input  logic         mdio_i
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] sr, wd;
  logic rd, cur_ta2, cur_data, bit_n, oe_n, fall_stb, rise_stb, acc;
  mdio_master_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .aclk, .areset, .en(state != IDLE), .mdc, .fall_stb, .rise_stb
  );
  assign bus.cmd_ready = state == IDLE && !bus.rsp_valid;
  assign acc = bus.cmd_valid && bus.cmd_ready;
  assign busy = state != IDLE || bus.rsp_valid;
  // state/cnt name the bit that goes on the wire at the next mdc fall
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    oe_n = 1'b0;
    bit_n = 1'b1;
    if (acc) begin
      state_n = PRE_LEN == 0 ? HDR : PRE;
      cnt_n = CNT_W'(PRE_LEN == 0 ? HDR_BITS - 1 : PRE_LEN - 1);
    end else if (fall_stb) begin
      cnt_n = cnt - 1'b1;
      oe_n = state != DONE && !(rd && (state == TA || state == DATA));
      bit_n = !oe_n || state == PRE || (state == DATA ? wd[DATA_W-1] : sr[DATA_W-1]);
      if (cnt == '0) begin
        state_n = state == PRE ? HDR : state == HDR ? TA : state == TA ? DATA : state == DATA ? DONE : IDLE;
        cnt_n = state == PRE ? CNT_W'(HDR_BITS - 1) : state == HDR ? CNT_W'(1) : state == TA ? CNT_W'(DATA_W - 1) : '0;
      end
    end
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      wd <= '0;
      rd <= 1'b0;
      cur_ta2 <= 1'b0;
      cur_data <= 1'b0;
      mdio_o <= 1'b1;
      mdio_oe <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (acc) begin
        sr <= {MDIO_ST, bus.cmd_write ? MDIO_OP_WR : MDIO_OP_RD, bus.cmd_phyad, bus.cmd_regad, MDIO_TA_WR};
        wd <= bus.cmd_wdata;
        rd <= !bus.cmd_write;
        bus.rsp_rdata <= '0;
        bus.rsp_err <= 1'b0;
      end
      if (fall_stb) begin
        mdio_o <= bit_n;
        mdio_oe <= oe_n;
        cur_ta2 <= state == TA && cnt == '0;
        cur_data <= state == DATA;
        if (state == HDR || state == TA) sr <= sr << 1;
        if (state == DATA) wd <= wd << 1;
      end
      if (rise_stb && rd && cur_ta2) bus.rsp_err <= mdio_i;
      if (rise_stb && rd && cur_data) bus.rsp_rdata <= {bus.rsp_rdata[DATA_W-2:0], mdio_i};
      if (fall_stb && state == DONE) bus.rsp_valid <= 1'b1;
      else if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
    end
endmodule
